// File: rtl/ifetch_ctrl_if.sv
// ifetch_ctrl_if: instruction-memory request/acknowledge bus.
//   imem_req   : fetch unit requests a word
//   imem_addr  : word-aligned request address, stable while req is held
//   imem_ack   : memory response valid (only while imem_req=1, may be same cycle)
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch sequencer, slave = instruction memory.
interface ifetch_ctrl_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input  imem_ack, imem_rdata);
  modport slave  (input  imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: fetch sequencer for the pipelined CPU front end.
// Owns the fetch PC, drives a variable-latency request/ack instruction memory
// and holds one registered instruction slot for the IF/ID register.
// Ports:
//   clk, rst         : clock, synchronous active-high reset
//   stall            : IF/ID cannot accept a new instruction this cycle
//   EX_jump, EX_npc  : redirect from EX (target low two bits ignored)
//   imem             : instruction-memory bus (master side)
//   IF_pc / IF_pc4   : PC of held instruction and PC+4
//   IF_inst          : held instruction, NOP_INST when IF_valid=0
//   IF_valid         : slot holds a valid instruction
module ifetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               EX_jump,
  input  logic [31:0]        EX_npc,
  ifetch_ctrl_if.master      imem,
  output logic [31:0]        IF_pc,
  output logic [31:0]        IF_pc4,
  output logic [31:0]        IF_inst,
  output logic               IF_valid
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] pc_q, inst_q;
  logic        valid_q;

  logic        slot_free, req, ack, load, clr;
  logic [31:0] npc_aligned;

  assign slot_free   = !valid_q || !stall;
  assign npc_aligned = EX_npc & ~32'd3;
  // ack is only meaningful while we are actually requesting
  assign ack         = imem.imem_ack && req;

  // bus outputs
  always_comb begin
    req            = 1'b0;
    imem.imem_addr = fetch_pc_q;
    case (state_q)
      S_REQ:  req = slot_free;
      S_WAIT: req = 1'b1;
      S_DROP: begin
        req            = 1'b1;
        imem.imem_addr = drop_addr_q;   // keep presenting the abandoned address
      end
      default: req = 1'b0;
    endcase
    if (rst) begin
      req            = 1'b0;
      imem.imem_addr = RESET_PC;
    end
    imem.imem_req = req;
  end

  // next state / slot control
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    drop_addr_d = drop_addr_q;
    load        = 1'b0;
    clr         = 1'b0;
    case (state_q)
      S_REQ: begin
        if (!slot_free) begin
          state_d = S_HOLD;
        end else if (ack) begin
          load       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
        end else begin
          state_d = S_WAIT;
          clr     = !stall;
        end
      end
      S_WAIT: begin
        // slot is always empty here: entry required a free slot and no ack
        if (ack) begin
          load       = 1'b1;
          fetch_pc_d = fetch_pc_q + 32'd4;
          state_d    = S_REQ;
        end else begin
          clr = !stall;
        end
      end
      S_HOLD: begin
        if (!stall) begin
          state_d = S_REQ;
          clr     = 1'b1;
        end
      end
      S_DROP: begin
        if (ack) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase

    // redirect beats stall; any same-cycle ack data is discarded
    if (EX_jump) begin
      load       = 1'b0;
      clr        = 1'b1;
      fetch_pc_d = npc_aligned;
      if (state_q != S_DROP) begin
        if (req && !ack) begin
          // memory already owns this access: let it finish into DROP
          state_d     = S_DROP;
          drop_addr_d = fetch_pc_q;
        end else begin
          state_d = S_REQ;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      drop_addr_q <= RESET_PC;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      drop_addr_q <= drop_addr_d;
      if (load) begin
        valid_q <= 1'b1;
        pc_q    <= fetch_pc_q;
        inst_q  <= imem.imem_rdata;
      end else if (clr) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign IF_pc    = pc_q;
  assign IF_pc4   = pc_q + 32'd4;
  assign IF_inst  = valid_q ? inst_q : NOP_INST;
  assign IF_valid = valid_q;

endmodule
